mem_port_arbiter: RTL and testbench

//  Arbitrates the single memory port between bus masters: instruction fetch (req 0) and load/store (req 1).

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter owning the single memory port
//
// Grants the memory port to one requester at a time, latches its address,
// write data and direction, runs the access until mfc or timeout, and
// returns a one-cycle ack (with err on timeout) to the granted master.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req, req_we         per-master request and direction (1 = write)
//   req_addr, req_wdata per-master address / write data, master i at [i*W +: W]
//   gnt, ack, err       one-hot owner, one-cycle completion pulse, timeout flag
//   rdata, busy         captured read data, high in ACCESS and RESP
//   mem_en, mem_rw      memory enable and direction
//   mem_addr, mem_wdata latched address / write data to memory
//   mem_rdata, mfc      memory read data and function-complete handshake
module mem_port_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_rw,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mfc
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   owner, owner_n;
    logic [LW-1:0]   last, last_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n, ack_n;
    logic            err_n, busy_n, mem_en_n, mem_rw_n;
    logic [AW-1:0]   mem_addr_n;
    logic [DW-1:0]   mem_wdata_n, rdata_n;

    logic [AW-1:0]   addr_arr  [N_REQ];
    logic [DW-1:0]   wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign wdata_arr[i] = req_wdata[i*DW +: DW];
    end

    // Round-robin search starting just after the last winner, so a master
    // cannot win twice in a row while another one is waiting.
    logic          found;
    logic [LW-1:0] win;
    always_comb begin
        int idx;
        logic [LW-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last) + k) % N_REQ;
            cand = LW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= LW'(N_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            err       <= err_n;
            busy      <= busy_n;
            mem_en    <= mem_en_n;
            mem_rw    <= mem_rw_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rdata     <= rdata_n;
        end
    end

    // Next-state logic computes the registered value of every output, so
    // each output changes together with the state it belongs to.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        cnt_n       = cnt;
        gnt_n       = gnt;
        ack_n       = '0;
        err_n       = err;
        busy_n      = busy;
        mem_en_n    = mem_en;
        mem_rw_n    = mem_rw;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        rdata_n     = rdata;

        unique case (state)
            IDLE: begin
                gnt_n    = '0;
                err_n    = 1'b0;
                busy_n   = 1'b0;
                mem_en_n = 1'b0;
                mem_rw_n = 1'b0;
                if (found) begin
                    state_n     = ACCESS;
                    owner_n     = win;
                    gnt_n[win]  = 1'b1;
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    mem_en_n    = 1'b1;
                    mem_rw_n    = req_we[win];
                    mem_addr_n  = addr_arr[win];
                    mem_wdata_n = wdata_arr[win];
                end
            end
            ACCESS: begin
                cnt_n = cnt + CW'(1);
                // mfc is checked first so it wins over a coincident timeout
                if (mfc) begin
                    if (!mem_rw) begin
                        rdata_n = mem_rdata;
                    end
                    err_n        = 1'b0;
                    state_n      = RESP;
                    mem_en_n     = 1'b0;
                    mem_rw_n     = 1'b0;
                    ack_n[owner] = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_n        = 1'b1;
                    state_n      = RESP;
                    mem_en_n     = 1'b0;
                    mem_rw_n     = 1'b0;
                    ack_n[owner] = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
                last_n  = owner;
                gnt_n   = '0;
                busy_n  = 1'b0;
                err_n   = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mfc;

    int vectors;
    int miscompares;

    mem_port_arbiter #(
        .N_REQ(2), .AW(16), .DW(16), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mfc(mfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        logic [1:0] exp_g;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        req       = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mfc       = 1'b0;

        // reset state
        tick(); tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_rw", 32'(mem_rw), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        rst = 1'b1;

        // 1: single read from master 0, mfc in first ACCESS cycle
        req = 2'b01; req_we = 2'b00; req_addr[15:0] = 16'h0010;
        mem_rdata = 16'hBEEF; mfc = 1'b1;
        tick();
        check("t1_mem_en", 32'(mem_en), 1);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0010);
        check("t1_mem_rw", 32'(mem_rw), 0);
        check("t1_ack_early", 32'(ack), 0);
        tick();
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_rdata", 32'(rdata), 32'hBEEF);
        check("t1_err", 32'(err), 0);
        check("t1_resp_mem_en", 32'(mem_en), 0);
        check("t1_resp_gnt", 32'(gnt), 32'h1);
        req = 2'b00; mfc = 1'b0;
        tick();
        check("t1_idle_ack", 32'(ack), 0);
        check("t1_idle_gnt", 32'(gnt), 0);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_hold_addr", 32'(mem_addr), 32'h0010);

        // 2: both masters requesting continuously, fresh priority after reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 2'b11; req_we = 2'b00;
        req_addr = {16'h0200, 16'h0100};
        mem_rdata = 16'h5A5A; mfc = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check("t2_gnt", 32'(gnt), 32'(exp_g));
            check("t2_addr", 32'(mem_addr), (t % 2 == 0) ? 32'h0100 : 32'h0200);
            tick();
            check("t2_ack", 32'(ack), 32'(exp_g));
            tick();
            check("t2_idle_gnt", 32'(gnt), 0);
        end
        check("t2_rdata", 32'(rdata), 32'h5A5A);
        req = 2'b00; mfc = 1'b0;

        // 3: write from master 1, mfc in the fourth ACCESS cycle
        req = 2'b10; req_we = 2'b10;
        req_addr[31:16] = 16'h0042; req_wdata[31:16] = 16'h1234;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t3_mem_en", 32'(mem_en), 1);
            check("t3_mem_rw", 32'(mem_rw), 1);
            check("t3_mem_addr", 32'(mem_addr), 32'h0042);
            check("t3_mem_wdata", 32'(mem_wdata), 32'h1234);
            check("t3_ack_early", 32'(ack), 0);
            if (i == 3) mfc = 1'b1;
            tick();
        end
        check("t3_ack", 32'(ack), 32'h2);
        check("t3_err", 32'(err), 0);
        check("t3_rdata_keep", 32'(rdata), 32'h5A5A);
        req = 2'b00; mfc = 1'b0; req_we = 2'b00;
        tick();
        check("t3_hold_addr", 32'(mem_addr), 32'h0042);
        check("t3_hold_wdata", 32'(mem_wdata), 32'h1234);

        // 4: mfc never arrives -> timeout after 16 ACCESS cycles
        req = 2'b01; req_addr[15:0] = 16'h0077; mem_rdata = 16'hDEAD;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_en) break;
            cnt++;
            tick();
        end
        check("t4_en_cycles", 32'(cnt), 16);
        check("t4_ack", 32'(ack), 32'h1);
        check("t4_err", 32'(err), 1);
        check("t4_rdata_keep", 32'(rdata), 32'h5A5A);
        req = 2'b00;
        tick();
        check("t4_idle_err", 32'(err), 0);
        check("t4_idle_ack", 32'(ack), 0);

        // 5: asynchronous reset in the middle of an access
        req = 2'b10; req_addr[31:16] = 16'h0099;
        tick();
        check("t5_mem_en", 32'(mem_en), 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_en", 32'(mem_en), 0);
        check("t5_async_gnt", 32'(gnt), 0);
        check("t5_async_busy", 32'(busy), 0);
        tick();
        check("t5_no_ack", 32'(ack), 0);
        rst = 1'b1;
        req = 2'b11; mfc = 1'b1; mem_rdata = 16'h1111;
        tick();
        check("t5_prio_gnt", 32'(gnt), 32'h1);
        tick();
        check("t5_prio_ack", 32'(ack), 32'h1);
        check("t5_rdata", 32'(rdata), 32'h1111);
        req = 2'b00; mfc = 1'b0;
        tick();

        // 6: address change and req drop during ACCESS are ignored
        req = 2'b10; req_we = 2'b00; req_addr[31:16] = 16'h0300; mem_rdata = 16'hCAFE;
        tick();
        check("t6_addr", 32'(mem_addr), 32'h0300);
        req_addr[31:16] = 16'hFFFF; req = 2'b00; req_we = 2'b10;
        tick();
        check("t6_addr_held", 32'(mem_addr), 32'h0300);
        check("t6_rw_held", 32'(mem_rw), 0);
        check("t6_en", 32'(mem_en), 1);
        mfc = 1'b1;
        tick();
        check("t6_ack", 32'(ack), 32'h2);
        check("t6_rdata", 32'(rdata), 32'hCAFE);
        mfc = 1'b0;
        tick();
        check("t6_ack_once", 32'(ack), 0);
        tick();
        check("t6_idle_ack", 32'(ack), 0);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_hold_addr", 32'(mem_addr), 32'h0300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
